// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: streaming Reed-Solomon syndrome calculator.
//
// Accepts one received symbol per cycle (highest-degree coefficient first) and
// evaluates the received polynomial at alpha^(FCR+j), j = 0..ROOTS_NUM-1, using
// Horner's rule: one GF multiply and one XOR per syndrome per accepted symbol.
// The finished syndrome set is held on the output until downstream accepts it.
//
// Optional feature macro: RS_SYNDR_LEN_CHECK_EN
//   defined   -> symbol counter flags codewords whose length differs from N_LEN
//   undefined -> no counter, m_len_err tied low
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   s_valid    in   input symbol valid
//   s_ready    out  block can accept a symbol (!m_valid || m_ready)
//   s_data     in   received symbol
//   s_last     in   last symbol of the codeword
//   m_valid    out  syndrome set valid
//   m_ready    in   downstream accepts the syndrome set
//   m_syndr    out  syndrome j at [j*SYMB_WIDTH +: SYMB_WIDTH]
//   m_err_det  out  at least one syndrome nonzero
//   m_len_err  out  codeword length differed from N_LEN
module rs_syndrome_calc #(
   parameter int unsigned SYMB_WIDTH = 8,
   parameter int unsigned POLY       = 285,
   parameter int unsigned N_LEN      = 255,
   parameter int unsigned ROOTS_NUM  = 16,
   parameter int unsigned FCR        = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [SYMB_WIDTH-1:0]            s_data,
   input  logic                             s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [ROOTS_NUM*SYMB_WIDTH-1:0]  m_syndr,
   output logic                             m_err_det,
   output logic                             m_len_err
);

   localparam int unsigned ORDER = (1 << SYMB_WIDTH) - 1;
   localparam logic [SYMB_WIDTH-1:0] POLY_LOW = SYMB_WIDTH'(POLY);

   // Multiply by alpha: LFSR shift with reduction by the generator polynomial.
   function automatic logic [SYMB_WIDTH-1:0] gf_xtime(input logic [SYMB_WIDTH-1:0] v);
      return {v[SYMB_WIDTH-2:0], 1'b0} ^ (v[SYMB_WIDTH-1] ? POLY_LOW : '0);
   endfunction

   function automatic logic [SYMB_WIDTH-1:0] gf_pow(input int unsigned e);
      logic [SYMB_WIDTH-1:0] v;
      v = SYMB_WIDTH'(1);
      for (int unsigned i = 0; i < e; i++) begin
         v = gf_xtime(v);
      end
      return v;
   endfunction

   // Shift-and-add GF multiply, MSB of b first.
   function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
      logic [SYMB_WIDTH-1:0] p;
      p = '0;
      for (int i = SYMB_WIDTH - 1; i >= 0; i--) begin
         p = gf_xtime(p) ^ (b[i] ? a : '0);
      end
      return p;
   endfunction

   logic                            w_in_fire;
   logic                            w_last_fire;
   logic [ROOTS_NUM*SYMB_WIDTH-1:0] w_acc_nxt;
   logic [ROOTS_NUM*SYMB_WIDTH-1:0] r_acc;
   logic [ROOTS_NUM*SYMB_WIDTH-1:0] r_syndr;
   logic                            r_first;
   logic                            r_valid;
   logic                            r_err_det;

   assign s_ready     = !r_valid || m_ready;
   assign w_in_fire   = s_valid && s_ready;
   assign w_last_fire = w_in_fire && s_last;

   for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_root
      localparam logic [SYMB_WIDTH-1:0] ROOT = gf_pow((FCR + j) % ORDER);
      logic [SYMB_WIDTH-1:0] w_acc;
      assign w_acc = r_acc[j*SYMB_WIDTH +: SYMB_WIDTH];
      // First symbol of a codeword overwrites any stale accumulation.
      assign w_acc_nxt[j*SYMB_WIDTH +: SYMB_WIDTH] =
         r_first ? s_data : (gf_mult(w_acc, ROOT) ^ s_data);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_first   <= 1'b1;
         r_valid   <= 1'b0;
         r_syndr   <= '0;
         r_err_det <= 1'b0;
      end else begin
         if (w_in_fire) begin
            r_acc   <= w_acc_nxt;
            r_first <= s_last;
         end
         // A new set arriving in the same cycle as an output transfer keeps m_valid high.
         if (w_last_fire) begin
            r_syndr   <= w_acc_nxt;
            r_err_det <= |w_acc_nxt;
            r_valid   <= 1'b1;
         end else if (m_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef RS_SYNDR_LEN_CHECK_EN
   localparam int unsigned CNT_W = $clog2(N_LEN + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_len_err;

   // Counts beats before s_last; saturates at N_LEN so long codewords still flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_len_err <= 1'b0;
      end else if (w_in_fire) begin
         if (s_last) begin
            r_cnt     <= '0;
            r_len_err <= (r_cnt != CNT_W'(N_LEN - 1));
         end else if (r_cnt != CNT_W'(N_LEN)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign m_len_err = r_len_err;
`else
   assign m_len_err = 1'b0;
`endif

   assign m_valid   = r_valid;
   assign m_syndr   = r_syndr;
   assign m_err_det = r_err_det;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb_rs_syndrome_calc: randomized bench for rs_syndrome_calc.
// Expected syndromes come from direct polynomial evaluation with log/antilog
// tables: S_j = XOR_i r_i * alpha^((FCR+j)*deg_i).
module tb_rs_syndrome_calc;

   localparam int unsigned W    = 8;
   localparam int unsigned POLY = 285;
   localparam int unsigned NL   = 255;
   localparam int unsigned RN   = 16;
   localparam int unsigned FCR  = 0;
   localparam int unsigned SW   = RN * W;

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [SW-1:0] m_syndr;
   logic          m_err_det;
   logic          m_len_err;

   rs_syndrome_calc #(
      .SYMB_WIDTH (W),
      .POLY       (POLY),
      .N_LEN      (NL),
      .ROOTS_NUM  (RN),
      .FCR        (FCR)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_syndr   (m_syndr),
      .m_err_det (m_err_det),
      .m_len_err (m_len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] syn;
      logic          err;
      logic          len;
   } exp_t;

   int unsigned   n_vec;
   int unsigned   n_err;
   logic [W-1:0]  gexp [0:254];
   int            glog [0:255];
   logic [W-1:0]  cw_q [$];
   exp_t          exp_q [$];
   exp_t          cur_exp;
   logic [SW-1:0] last_syn;
   int            rdy_mode;  // 0: always ready, 1: random, 2: held low

   task automatic check_eq(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t ref_model();
      exp_t         r;
      int           L;
      int           e;
      logic [W-1:0] s;
      L     = cw_q.size();
      r.syn = '0;
      for (int j = 0; j < int'(RN); j++) begin
         e = (int'(FCR) + j) % 255;
         s = '0;
         for (int i = 0; i < L; i++) begin
            if (cw_q[i] != 0) s ^= gexp[(glog[cw_q[i]] + e * (L - 1 - i)) % 255];
         end
         r.syn[j*W +: W] = s;
      end
      r.err = (r.syn != '0);
`ifdef RS_SYNDR_LEN_CHECK_EN
      r.len = (L != int'(NL));
`else
      r.len = 1'b0;
`endif
      return r;
   endfunction

   task automatic send_beat(input logic [W-1:0] d, input logic last);
      bit acc;
      int t;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      acc     = 1'b0;
      t       = 0;
      while (!acc && t < 2000) begin
         @(negedge clk);
         acc = s_ready;
         if (acc && last) exp_q.push_back(cur_exp);
         @(posedge clk);
         #1;
         t++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) check_eq("beat_timeout", SW'(acc), SW'(1));
      else if (last) check_eq("latency_mvalid", SW'(m_valid), SW'(1));
   endtask

   task automatic send_cw(input int gap_max);
      int n;
      cur_exp = ref_model();
      n       = cw_q.size();
      for (int i = 0; i < n; i++) begin
         send_beat(cw_q[i], i == n - 1);
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_valid) && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_eq("drain", SW'(exp_q.size()), SW'(0));
   endtask

   task automatic build_cw(input int len, input int kind);
      cw_q.delete();
      for (int i = 0; i < len; i++) begin
         case (kind)
            0:       cw_q.push_back(8'h00);
            1:       cw_q.push_back((i == 0) ? 8'h01 : 8'h00);
            2:       cw_q.push_back((i == len - 1) ? 8'h01 : 8'h00);
            default: cw_q.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom));
         endcase
      end
   endtask

   // Output monitor and scoreboard; samples on the falling edge.
   initial begin : monitor
      logic [SW-1:0] prev_syn;
      logic          prev_err;
      logic          prev_len;
      logic          prev_hold;
      exp_t          e;
      prev_syn  = '0;
      prev_err  = 1'b0;
      prev_len  = 1'b0;
      prev_hold = 1'b0;
      m_ready   = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check_eq("hold_valid", SW'(m_valid), SW'(1));
               check_eq("hold_syndr", m_syndr, prev_syn);
               check_eq("hold_flags", SW'({m_err_det, m_len_err}), SW'({prev_err, prev_len}));
            end
            if (m_valid && !m_ready) check_eq("stall_sready", SW'(s_ready), SW'(0));
            check_eq("valid_without_set", SW'(m_valid && exp_q.size() == 0), SW'(0));
            if (m_valid && m_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("syndr", m_syndr, e.syn);
               check_eq("err_det", SW'(m_err_det), SW'(e.err));
               check_eq("len_err", SW'(m_len_err), SW'(e.len));
               last_syn = m_syndr;
            end
            prev_hold = m_valid && !m_ready;
            prev_syn  = m_syndr;
            prev_err  = m_err_det;
            prev_len  = m_len_err;
         end
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
         endcase
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int v;
      int t;
      n_vec    = 0;
      n_err    = 0;
      last_syn = '0;
      rdy_mode = 0;
      v        = 1;
      for (int k = 0; k < 255; k++) begin
         gexp[k] = W'(v);
         glog[v] = k;
         v = v << 1;
         if ((v & 256) != 0) v ^= int'(POLY);
      end
      glog[0] = 0;

      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_sready", SW'(s_ready), SW'(1));
      check_eq("rst_mvalid", SW'(m_valid), SW'(0));
      check_eq("rst_syndr", m_syndr, '0);
      check_eq("rst_flags", SW'({m_err_det, m_len_err}), SW'(0));

      // All-zero codeword.
      build_cw(255, 0);
      send_cw(0);
      drain();

      // Leading 0x01: S_j = alpha^(254*j).
      build_cw(255, 1);
      send_cw(0);
      drain();
      check_eq("s0_is_01", SW'(last_syn[7:0]), SW'(8'h01));
      check_eq("s1_is_8e", SW'(last_syn[15:8]), SW'(8'h8E));

      // Trailing 0x01: every syndrome is 0x01.
      build_cw(255, 2);
      send_cw(0);
      drain();
      check_eq("all_01", last_syn, {RN{8'h01}});

      // Back-to-back with output held for 5 cycles after the first set.
      rdy_mode = 2;
      fork
         begin
            build_cw(40, 3);
            send_cw(0);
            build_cw(255, 3);
            send_cw(0);
         end
         begin
            t = 0;
            while (!m_valid && t < 1000) begin
               @(posedge clk);
               #1;
               t++;
            end
            check_eq("b2b_first_valid", SW'(m_valid), SW'(1));
            repeat (5) @(posedge clk);
            #1;
            rdy_mode = 0;
         end
      join
      drain();

      // Short codewords: length 10 and length 1.
      build_cw(10, 3);
      send_cw(1);
      build_cw(1, 3);
      send_cw(0);
      drain();

      // Reset mid-codeword, then a full zero codeword.
      build_cw(100, 3);
      for (int i = 0; i < 100; i++) send_beat(cw_q[i], 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("midrst_mvalid", SW'(m_valid), SW'(0));
      check_eq("midrst_sready", SW'(s_ready), SW'(1));
      check_eq("midrst_syndr", m_syndr, '0);
      build_cw(255, 0);
      send_cw(0);
      drain();

      // Randomized codewords, lengths, gaps and backpressure.
      rdy_mode = 1;
      for (int k = 0; k < 10; k++) begin
         build_cw(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : 255, 3);
         send_cw(2);
      end
      rdy_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Streaming Reed-Solomon syndrome calculator. Sits directly upstream of the decoder's key-equation and error-locator stages and downstream of the channel symbol interface. It accepts one received symbol per cycle and evaluates the received polynomial at ROOTS_NUM consecutive powers of alpha using Horner's rule, built from `gf_mult` instances. It then presents all syndromes plus an error-detected flag for one codeword at a time.

## Interface
- SYMB_WIDTH, 8, symbol width in bits; GF(2^SYMB_WIDTH)
- POLY, 285, field generator polynomial, including the x^SYMB_WIDTH term
- N_LEN, 255, codeword length in symbols; must be <= 2^SYMB_WIDTH-1
- ROOTS_NUM, 16, number of syndromes (2T)
- FCR, 0, first consecutive root; syndrome j is evaluated at alpha^(FCR+j)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input symbol valid
- s_ready  out  1  block can accept a symbol
- s_data  in  SYMB_WIDTH  received symbol; highest-degree coefficient first
- s_last  in  1  last symbol of the codeword
- m_valid  out  1  syndrome set valid
- m_ready  in  1  downstream accepts the syndrome set
- m_syndr  out  ROOTS_NUM*SYMB_WIDTH  syndrome j is at bits [j*SYMB_WIDTH +: SYMB_WIDTH]
- m_err_det  out  1  at least one syndrome is nonzero
- m_len_err  out  1  codeword length differed from N_LEN

## Operation
- Transfer rules:
  - An input beat transfers when s_valid && s_ready.
  - An output set transfers when m_valid && m_ready.
- Root constants: root_j = alpha^(FCR+j). They are generated combinationally with the LFSR rule: shift left, then XOR POLY[SYMB_WIDTH-1:0] when the previous MSB was 1. Exponents are reduced mod 2^SYMB_WIDTH-1.
- Internal first flag: set at reset and after every accepted s_last beat; cleared after any other accepted beat.
- Accumulator update on each accepted beat, for every j:
  - If first=1: acc_j <= s_data.
  - Otherwise: acc_j <= gf_mult(acc_j, root_j) ^ s_data.
- On an accepted s_last beat:
  - m_syndr <= the updated acc values, i.e. the value including the current s_data.
  - m_err_det <= OR-reduce of those updated values.
  - m_valid <= 1.
- m_valid clears on output transfer unless a new s_last beat is accepted in the same cycle. In that case m_valid stays 1 and the outputs load the new set.
- s_ready = !m_valid || m_ready. This is combinational, with no dependency on s_valid.
- Length-1 codeword (first and last on the same beat): syndromes = s_data for all j.
- Arithmetic is GF(2) only. Addition is XOR. There is no integer overflow.
- Reset at any point, including mid-codeword:
  - Partial accumulation is discarded.
  - Accumulators = 0, first = 1.
  - All outputs return to their reset values.

## Timing
- Reset values: s_ready=1, m_valid=0, m_syndr=0, m_err_det=0, m_len_err=0.
- Throughput: one symbol per cycle while m_valid is clear or m_ready is high.
- Latency: m_valid rises on the first clock edge after the accepted s_last beat (one cycle).
- Output hold: while m_valid && !m_ready, s_ready=0, and m_syndr, m_err_det and m_len_err are held stable.
- Input gaps: cycles with s_valid=0 leave accumulators, the symbol counter and the first flag unchanged.
- Multiplier path: each cycle contains one GF multiply and one XOR per syndrome. There is no internal pipelining.

## Configuration
- RS_SYNDR_LEN_CHECK_EN defined:
  - Adds a symbol counter (width clog2(N_LEN+1)), cleared at reset and on every accepted s_last beat, incremented on other accepted beats.
  - On an accepted s_last beat, m_len_err <= (counter != N_LEN-1).
  - The counter saturates at N_LEN and does not wrap.
- RS_SYNDR_LEN_CHECK_EN undefined:
  - The counter is absent.
  - m_len_err is tied to 0.
  - All other behaviour is identical.

## Test plan
- Defaults, 255 zero symbols with s_last on the 255th, m_ready=1 -> m_valid pulses 1 cycle later; m_syndr all 0; m_err_det=0; m_len_err=0.
- First symbol 0x01, then 254 zeros -> S_0=0x01, S_1=0x8E (alpha^254), S_j=alpha^(254*j mod 255); m_err_det=1.
- First 254 symbols 0x00, last symbol 0x01 -> every S_j=0x01; m_err_det=1.
- Back-to-back codewords with m_ready held 0 for 5 cycles after the first set -> s_ready=0 and m_syndr stable for those 5 cycles; the second codeword then completes with correct syndromes; no symbol lost.
- With RS_SYNDR_LEN_CHECK_EN, s_last on beat 10 -> m_len_err=1. Without the macro, same stimulus -> m_len_err=0.
- rst asserted for 1 cycle after 100 symbols of a codeword, then a full all-zero codeword -> syndromes all 0; no m_valid before the new s_last.
